// File: rtl/sync_fifo_param.sv
//-----------------------------------------------------------------------------
// sync_fifo_param
//
// Single-clock parametrised FIFO. This is the same-clock counterpart of the
// dual-clock FIFO, with the same producer (winc/full) and consumer
// (rinc/rempty) handshake. It also provides an occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
//
// Parameters
//   DATA_WIDTH  width of write_data / read_data
//   ADDR_WIDTH  pointer width, DEPTH = 2**ADDR_WIDTH entries
//   AF_LEVEL    almost_full  when count >= AF_LEVEL   (1 .. DEPTH)
//   AE_LEVEL    almost_empty when count <= AE_LEVEL   (0 .. DEPTH-1)
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   write_data    data to store
//   winc          write request (accepted when not full)
//   rinc          read request  (accepted when not empty)
//   err_clr       clears overflow / underflow
//   read_data     registered read data, holds when no read is accepted
//   full          count == DEPTH
//   rempty        count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         occupancy, 0 .. DEPTH
//   overflow      sticky, a write was attempted while full
//   underflow     sticky, a read was attempted while empty
//
// Every output comes from a register. There is no combinational path from
// any input to any output.
//-----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  winc,
  input  logic                  rinc,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  // The thresholds are sized to the count width so that every flag compare
  // has matching operand widths.
  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0]         AE_C     = CW'(AE_LEVEL);
  localparam logic [CW-1:0]         CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

  // The storage array is not reset. After a reset, old contents cannot be
  // reached because both pointers and count return to zero.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [CW-1:0]         next_count;

  // Acceptance uses the registered flags of this cycle. A simultaneous read
  // never frees a slot for a write while full. A simultaneous write never
  // supplies data to a read while empty, because there is no bypass.
  always_comb begin
    wr_ok = winc & ~full;
    rd_ok = rinc & ~rempty;
  end

  // Next occupancy: net change of accepted writes minus accepted reads.
  always_comb begin
    next_count = count;
    case ({wr_ok, rd_ok})
      2'b10:   next_count = count + CNT_ONE;
      2'b01:   next_count = count - CNT_ONE;
      2'b11:   next_count = count;
      default: next_count = count;
    endcase
  end

  // Storage write port. Only accepted writes touch the array.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wptr] <= write_data;
    end
  end

  // Pointers. They wrap naturally from DEPTH-1 to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= PTR_ZERO;
      rptr <= PTR_ZERO;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Registered read data. It holds its value when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= DATA_ZERO;
    end else if (rd_ok) begin
      read_data <= mem[rptr];
    end else begin
      read_data <= read_data;
    end
  end

  // Count and status flags. The flags are derived from next_count, so they
  // change on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= CNT_ZERO;
      full         <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= next_count;
      full         <= (next_count == DEPTH_C);
      rempty       <= (next_count == CNT_ZERO);
      almost_full  <= (next_count >= AF_C);
      almost_empty <= (next_count <= AE_C);
    end
  end

  // Sticky error flags. A new offending request takes priority over err_clr
  // in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (winc & full)   | (overflow  & ~err_clr);
      underflow <= (rinc & rempty) | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
//-----------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Self-checking bench for sync_fifo_param with the default parameters.
//
// A queue-based model predicts every output. It is updated on each rising
// edge and compared with the DUT on every falling edge. Directed sequences
// add hand-computed literal checks at the points of interest: reset, fill,
// drain, the limits, wrap-around and mid-operation reset. Randomised traffic
// follows the directed sequences.
//-----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int AEL   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] write_data;
  logic          winc;
  logic          rinc;
  logic          err_clr;
  logic [DW-1:0] read_data;
  logic          full;
  logic          rempty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AFL),
    .AE_LEVEL  (AEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write_data  (write_data),
    .winc        (winc),
    .rinc        (rinc),
    .err_clr     (err_clr),
    .read_data   (read_data),
    .full        (full),
    .rempty      (rempty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  bit            m_ovf;
  bit            m_unf;
  bit            m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Model update. Acceptance is decided from the occupancy before this edge.
  always @(posedge clk) begin
    bit was_full;
    bit was_empty;
    bit wok;
    bit rok;
    if (rst) begin
      q.delete();
      m_rd    = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      wok = winc && !was_full;
      rok = rinc && !was_empty;
      if (rok) m_rd = q.pop_front();
      if (wok) q.push_back(write_data);
      m_ovf = (winc && was_full) || (m_ovf && !err_clr);
      m_unf = (rinc && was_empty) || (m_unf && !err_clr);
    end
  end

  // Compare every output with the model on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("count",        32'(count),        q.size());
      check("full",         32'(full),         32'(q.size() == DEPTH));
      check("rempty",       32'(rempty),       32'(q.size() == 0));
      check("almost_full",  32'(almost_full),  32'(q.size() >= AFL));
      check("almost_empty", 32'(almost_empty), 32'(q.size() <= AEL));
      check("read_data",    32'(read_data),    32'(m_rd));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("underflow",    32'(underflow),    32'(m_unf));
    end
  end

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic step(input bit rs, input bit w, input logic [DW-1:0] d,
                      input bit r, input bit c);
    rst        = rs;
    winc       = w;
    write_data = d;
    rinc       = r;
    err_clr    = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] v;
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; write_data = '0;

    // Reset for 2 cycles, then idle.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_count",  32'(count), 32'd0);
    check("rst_rempty", 32'(rempty), 32'd1);
    check("rst_ae",     32'(almost_empty), 32'd1);
    check("rst_full",   32'(full), 32'd0);
    check("rst_af",     32'(almost_full), 32'd0);
    check("rst_ovf",    32'(overflow), 32'd0);
    check("rst_unf",    32'(underflow), 32'd0);
    check("rst_rd",     32'(read_data), 32'd0);

    // Fill with 0x01..0x11. The 17th write overflows and is dropped.
    for (int i = 1; i <= 17; i++) begin
      v = 8'(i);
      step(1'b0, 1'b1, v, 1'b0, 1'b0);
      if (i == 13) check("fill_af13", 32'(almost_full), 32'd0);
      if (i == 14) check("fill_af14", 32'(almost_full), 32'd1);
      if (i == 15) check("fill_full15", 32'(full), 32'd0);
      if (i == 16) check("fill_full16", 32'(full), 32'd1);
    end
    check("fill_count", 32'(count), 32'd16);
    check("fill_ovf",   32'(overflow), 32'd1);

    // Drain with 17 reads. The 17th read underflows.
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      if (i <= 16) check("drain_data", 32'(read_data), 32'(i));
      if (i == 13) check("drain_ae13", 32'(almost_empty), 32'd0);
      if (i == 14) check("drain_ae14", 32'(almost_empty), 32'd1);
      if (i == 15) check("drain_empty15", 32'(rempty), 32'd0);
      if (i == 16) check("drain_empty16", 32'(rempty), 32'd1);
    end
    check("drain_unf",  32'(underflow), 32'd1);
    check("drain_hold", 32'(read_data), 32'h10);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_unf", 32'(underflow), 32'd0);

    // Empty with winc=rinc=1: the write is accepted and the read rejected.
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    check("empty_both_count", 32'(count), 32'd1);
    check("empty_both_unf",   32'(underflow), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    check("refill_full", 32'(full), 32'd1);

    // Full with winc=rinc=1: the read is accepted and the write rejected.
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    check("full_both_count", 32'(count), 32'd15);
    check("full_both_ovf",   32'(overflow), 32'd1);
    check("full_both_rd",    32'(read_data), 32'hA5);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Bring occupancy to 4, then run interleaved traffic within 3..5.
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_start", 32'(count), 32'd4);
    for (int i = 0; i < 40; i++) begin
      bit w;
      bit r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (q.size() >= 5) w = 1'b0;
      if (q.size() <= 3) r = 1'b0;
      step(1'b0, w, 8'($urandom), r, 1'b0);
    end

    // Raise occupancy to 9, then reset together with winc and rinc.
    for (int k = 0; k < 20 && q.size() < 9; k++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd9);
    step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    check("midrst_count",  32'(count), 32'd0);
    check("midrst_rempty", 32'(rempty), 32'd1);
    check("midrst_rd",     32'(read_data), 32'd0);
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_rd",    32'(read_data), 32'h3C);
    check("post_rst_empty", 32'(rempty), 32'd1);

    // Random traffic. Phases alternate write-heavy and read-heavy so that
    // both limits are reached. Resets and err_clr pulses are occasional.
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 60) % 2 == 0) ? 3 : 1;
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 3) < wp),
           8'($urandom),
           1'($urandom_range(0, 3) < (4 - wp)),
           1'($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
